// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-slot TDM link.
// Slot numbering and FSM encodings used by both link ends.
package tdm_demux4_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux4_slot_cnt2.sv
// 2-bit slot counter: enable, sync load, wraps 3 -> 0.
// Ports: clk, rst_n, en_i, ld_i, ld_val_i[1:0], cnt_o[1:0]; load beats enable.
module slot_cnt2
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              ld_i,
  input  logic [SLOT_W-1:0] ld_val_i,
  output logic [SLOT_W-1:0] cnt_o
);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) cnt_d = ld_val_i;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer with frame-sync lock and atomic frame update.
// Ports: clk, rst_n, in_valid/in_sync/in_data[W], out0..out3[W], out_valid, locked, sync_err.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_sync,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic         out_valid,
  output logic         locked,
  output logic         sync_err
);

  state_e state_q, state_d;

  logic [SLOT_W-1:0] slot;
  logic              cnt_en;
  logic              cnt_ld;
  logic [SLOT_W-1:0] cnt_val;

  logic st0_we, st1_we, st2_we;
  logic done, err;

  logic [W-1:0] stg0_q, stg1_q, stg2_q;
  logic [W-1:0] o0_q, o1_q, o2_q, o3_q;
  logic         ov_q, err_q;

  slot_cnt2 u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (cnt_en),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_val),
    .cnt_o    (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    st0_we  = 1'b0;
    st1_we  = 1'b0;
    st2_we  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (in_sync) begin
            state_d = ST_LOCKED;
            st0_we  = 1'b1;
            cnt_ld  = 1'b1;
            cnt_val = 2'd1;
          end
        end
        ST_LOCKED: begin
          if (in_sync) begin
            // early sync restarts the frame
            st0_we  = 1'b1;
            cnt_ld  = 1'b1;
            cnt_val = 2'd1;
            err     = (slot != 2'd0);
          end else begin
            unique case (slot)
              2'd0: begin
                err     = 1'b1;
                state_d = ST_HUNT;
                cnt_ld  = 1'b1;
                cnt_val = 2'd0;
              end
              2'd1: begin
                st1_we = 1'b1;
                cnt_en = 1'b1;
              end
              2'd2: begin
                st2_we = 1'b1;
                cnt_en = 1'b1;
              end
              2'd3: begin
                done   = 1'b1;
                cnt_en = 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg0_q <= '0;
      stg1_q <= '0;
      stg2_q <= '0;
      o0_q   <= '0;
      o1_q   <= '0;
      o2_q   <= '0;
      o3_q   <= '0;
      ov_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (st0_we) stg0_q <= in_data;
      if (st1_we) stg1_q <= in_data;
      if (st2_we) stg2_q <= in_data;
      if (done) begin
        o0_q <= stg0_q;
        o1_q <= stg1_q;
        o2_q <= stg2_q;
        o3_q <= in_data;
      end
      ov_q  <= done;
      err_q <= err;
    end
  end

  always_comb begin
    locked    = (state_q == ST_LOCKED);
    out_valid = ov_q;
    sync_err  = err_q;
    out0      = o0_q;
    out1      = o1_q;
    out2      = o2_q;
    out3      = o3_q;
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (W=8).
// Expected frames are queued by stimulus; a negedge monitor checks each out_valid.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_sync;
  logic [7:0] in_data;
  logic [7:0] out0, out1, out2, out3;
  logic       out_valid, locked, sync_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int e0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  tdm_demux4 #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_data   (in_data),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sync_err) err_cnt++;
    if (out_valid || sync_err)
      chk("pulse_excl", {31'd0, out_valid & sync_err}, 32'd0);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {out0, out1, out2, out3}, 32'hxxxxxxxx);
      end else begin
        chk("frame", {out0, out1, out2, out3}, exp_q.pop_front());
      end
    end
  end

  task automatic word(logic s, logic [7:0] d);
    in_valid = 1'b1;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = 8'h00;
    #3;
    chk("rst_outs", {out0, out1, out2, out3}, 32'h0);
    chk("rst_flags", {29'd0, out_valid, locked, sync_err}, 32'h0);
    #19;
    rst_n = 1'b1;
    idle(1);

    // back-to-back frame
    word(1, 8'hA0);
    word(0, 8'hA1);
    word(0, 8'hA2);
    exp_q.push_back(32'hA0A1A2A3);
    word(0, 8'hA3);
    idle(1);
    chk("t1_locked", {31'd0, locked}, 32'd1);
    chk("t1_err", err_cnt, 0);

    // stalls between every word
    word(1, 8'hA0); idle(2);
    word(0, 8'hA1); idle(2);
    word(0, 8'hA2); idle(2);
    exp_q.push_back(32'hA0A1A2A3);
    word(0, 8'hA3);
    idle(2);
    chk("t2_err", err_cnt, 0);

    // early sync
    word(1, 8'h10);
    word(0, 8'h11);
    word(1, 8'h20);
    word(0, 8'h21);
    word(0, 8'h22);
    exp_q.push_back(32'h20212223);
    word(0, 8'h23);
    idle(1);
    chk("t3_err", err_cnt, 1);
    chk("t3_out1", {24'd0, out1}, 32'h21);

    // missing sync at slot 0
    word(0, 8'h55);
    idle(1);
    chk("t4_err", err_cnt, 2);
    chk("t4_unlocked", {31'd0, locked}, 32'd0);
    chk("t4_hold", {out0, out1, out2, out3}, 32'h20212223);
    word(1, 8'h30);
    word(0, 8'h31);
    word(0, 8'h32);
    exp_q.push_back(32'h30313233);
    word(0, 8'h33);
    idle(1);
    chk("t4_relock", {31'd0, locked}, 32'd1);

    // drop to HUNT, then non-sync words are ignored
    word(0, 8'h99);
    idle(1);
    e0 = err_cnt;
    word(0, 8'h77);
    word(0, 8'h78);
    idle(1);
    chk("t5_noerr", err_cnt, e0);
    chk("t5_locked", {31'd0, locked}, 32'd0);
    chk("t5_hold", {out0, out1, out2, out3}, 32'h30313233);

    // async reset mid-frame
    word(1, 8'h40);
    word(0, 8'h41);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {out0, out1, out2, out3}, 32'h0);
    chk("t6_rst_flags", {29'd0, out_valid, locked, sync_err}, 32'h0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    e0 = err_cnt;
    word(0, 8'h42);
    word(0, 8'h43);
    idle(1);
    chk("t6_dropped", {out0, out1, out2, out3}, 32'h0);
    chk("t6_noerr", err_cnt, e0);
    chk("t6_hunt", {31'd0, locked}, 32'd0);

    // recovery after reset
    word(1, 8'h50);
    word(0, 8'h51);
    word(0, 8'h52);
    exp_q.push_back(32'h50515253);
    word(0, 8'h53);
    idle(2);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
